// File: rtl/fuzzify_ctrl.sv
// fuzzify_ctrl: runs a crisp input through N_MF trapezoid membership functions on a shared evaluator.
// Defining FUZZ_CFG_EN adds runtime-writable MF parameters (cfg ports and cfg_err).
module fuzzify_ctrl #(
    parameter int N_MF = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start_valid,
    output logic                   o_start_ready,
    input  logic signed [7:0]      i_x_in,
    output logic signed [7:0]      o_ev_x,
    output logic signed [7:0]      o_ev_a,
    output logic signed [7:0]      o_ev_b,
    output logic signed [7:0]      o_ev_c,
    output logic signed [7:0]      o_ev_d,
    input  logic [15:0]            i_ev_mu,
    output logic [N_MF*16-1:0]     o_mu_out,
    output logic [2:0]             o_mu_max_idx,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_busy
`ifdef FUZZ_CFG_EN
    ,
    input  logic                   i_cfg_we,
    input  logic [2:0]             i_cfg_idx,
    input  logic signed [7:0]      i_cfg_a,
    input  logic signed [7:0]      i_cfg_b,
    input  logic signed [7:0]      i_cfg_c,
    input  logic signed [7:0]      i_cfg_d,
    output logic                   o_cfg_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(N_MF - 1);

    // Packed as {a, b, c, d}, a in the top byte.
    function automatic logic [31:0] default_param(input logic [2:0] idx);
        case (idx)
            3'd0:    return 32'h8080_C0E0;
            3'd1:    return 32'hC0E0_0020;
            3'd2:    return 32'h0020_4060;
            3'd3:    return 32'h4060_7F7F;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // The evaluator reports full membership as 0x8000; clamp into Q1.15 range.
    function automatic logic [15:0] sat_q15(input logic [15:0] v);
        if (v > 16'h7FFF) begin
            return 16'h7FFF;
        end else begin
            return v;
        end
    endfunction

    state_t            r_state;
    state_t            w_state_nx;
    logic [2:0]        r_idx;
    logic signed [7:0] r_x;
    logic [15:0]       r_mu [N_MF];
    logic [15:0]       r_max_val;
    logic [2:0]        r_max_idx;
    logic [31:0]       w_param [8];
    logic [31:0]       w_sel;
    logic [15:0]       w_mu_sat;

`ifdef FUZZ_CFG_EN
    logic [31:0]       r_param [8];
    logic              r_cfg_err;
    logic              w_cfg_ok;

    assign w_cfg_ok = i_cfg_we && (r_state != S_EVAL) && ({1'b0, i_cfg_idx} < 4'(N_MF))
                      && (i_cfg_a <= i_cfg_b) && (i_cfg_b <= i_cfg_c) && (i_cfg_c <= i_cfg_d);

    // Parameter table and reject pulse; reset restores the default MF shapes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_param[i] <= default_param(3'(i));
            end
            r_cfg_err <= 1'b0;
        end else begin
            if (w_cfg_ok) begin
                r_param[i_cfg_idx] <= {i_cfg_a, i_cfg_b, i_cfg_c, i_cfg_d};
            end
            r_cfg_err <= i_cfg_we && !w_cfg_ok;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_param[i] = r_param[i];
        end
    end

    assign o_cfg_err = r_cfg_err;
`else
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_param[i] = default_param(3'(i));
        end
    end
`endif

    assign w_sel    = w_param[r_idx];
    assign w_mu_sat = sat_q15(i_ev_mu);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start_valid) begin
                    w_state_nx = S_EVAL;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_EVAL: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_EVAL;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Input latch, MF sweep and running maximum (strict > keeps the lowest index on ties).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx     <= 3'd0;
            r_x       <= 8'sd0;
            r_max_val <= 16'h0000;
            r_max_idx <= 3'd0;
            for (int i = 0; i < N_MF; i++) begin
                r_mu[i] <= 16'h0000;
            end
        end else if (r_state == S_IDLE) begin
            if (i_start_valid) begin
                r_x   <= i_x_in;
                r_idx <= 3'd0;
            end
        end else if (r_state == S_EVAL) begin
            for (int i = 0; i < N_MF; i++) begin
                if (r_idx == 3'(i)) begin
                    r_mu[i] <= w_mu_sat;
                end
            end
            if ((r_idx == 3'd0) || (w_mu_sat > r_max_val)) begin
                r_max_val <= w_mu_sat;
                r_max_idx <= r_idx;
            end
            if (r_idx == LAST_IDX) begin
                r_idx <= 3'd0;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    // Evaluator operands are only live during the sweep.
    always_comb begin
        o_ev_x = 8'sd0;
        o_ev_a = 8'sd0;
        o_ev_b = 8'sd0;
        o_ev_c = 8'sd0;
        o_ev_d = 8'sd0;
        if (r_state == S_EVAL) begin
            o_ev_x = r_x;
            o_ev_a = w_sel[31:24];
            o_ev_b = w_sel[23:16];
            o_ev_c = w_sel[15:8];
            o_ev_d = w_sel[7:0];
        end else begin
            o_ev_x = 8'sd0;
            o_ev_a = 8'sd0;
            o_ev_b = 8'sd0;
            o_ev_c = 8'sd0;
            o_ev_d = 8'sd0;
        end
    end

    always_comb begin
        o_mu_out = '0;
        for (int i = 0; i < N_MF; i++) begin
            o_mu_out[16*i +: 16] = r_mu[i];
        end
    end

    assign o_start_ready = (r_state == S_IDLE);
    assign o_busy        = (r_state == S_EVAL);
    assign o_out_valid   = (r_state == S_DONE);
    assign o_mu_max_idx  = r_max_idx;

endmodule
